// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module      : imm_gen_pipe
// Description : Pipelined immediate generator with 2-entry skid buffer.
//               Optional macro IMM_GEN_PC_ADD_EN adds in_pc/out_target.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_enc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
`ifdef IMM_GEN_PC_ADD_EN
    ,
    input  logic [XLEN-1:0]  in_pc,
    output logic [XLEN-1:0]  out_target
`endif
);

    localparam logic [2:0] ENC_R = 3'd0;
    localparam logic [2:0] ENC_I = 3'd1;
    localparam logic [2:0] ENC_S = 3'd2;
    localparam logic [2:0] ENC_B = 3'd3;
    localparam logic [2:0] ENC_U = 3'd4;
    localparam logic [2:0] ENC_J = 3'd5;
    localparam logic [2:0] ENC_Z = 3'd6;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // ------------------------------------------------------------------
    // Immediate decode on the input side
    // ------------------------------------------------------------------
    logic [31:0]      imm32;
    logic             zero_ext;
    logic             new_illegal;
    logic [XLEN-1:0]  new_imm;

    always_comb begin
        imm32       = 32'd0;
        zero_ext    = 1'b0;
        new_illegal = 1'b0;
        case (in_enc)
            ENC_R: imm32 = 32'd0;
            ENC_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            ENC_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            ENC_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            ENC_U: imm32 = {in_instr[31:12], 12'd0};
            ENC_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            ENC_Z: begin
                imm32    = {27'd0, in_instr[19:15]};
                zero_ext = 1'b1;
            end
            default: begin
                imm32       = in_instr;
                zero_ext    = 1'b1;
                new_illegal = 1'b1;
            end
        endcase
    end

    // Upper word replicates bit 31 except for the zero-extended classes.
    generate
        if (XLEN == 64) begin : g_xlen64
            assign new_imm = {{32{imm32[31] & ~zero_ext}}, imm32};
        end else begin : g_xlen32
            assign new_imm = imm32;
        end
    endgenerate

`ifdef IMM_GEN_PC_ADD_EN
    logic [XLEN-1:0] new_target;
    assign new_target = in_pc + new_imm;
`endif

    // ------------------------------------------------------------------
    // Buffer control
    // ------------------------------------------------------------------
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       load_head_new;
    logic       load_head_tail;
    logic       load_tail;

    assign in_ready  = (count != CNT_FULL);
    assign out_valid = (count != CNT_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Data moves are suppressed on flush so the invalid outputs keep their last value.
    assign load_head_new  = !flush && push &&
                            ((count == CNT_EMPTY) || ((count == CNT_ONE) && pop));
    assign load_tail      = !flush && push && (count == CNT_ONE) && !pop;
    assign load_head_tail = !flush && pop && (count == CNT_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CNT_EMPTY;
        end else if (flush) begin
            count <= CNT_EMPTY;
        end else begin
            case (count)
                CNT_EMPTY: if (push) count <= CNT_ONE;
                CNT_ONE: begin
                    if (push && !pop)
                        count <= CNT_FULL;
                    else if (!push && pop)
                        count <= CNT_EMPTY;
                end
                default: if (pop) count <= CNT_ONE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: head drives the outputs, tail is the skid slot
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  head_imm,  tail_imm;
    logic [TAG_W-1:0] head_tag,  tail_tag;
    logic             head_ill,  tail_ill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tail_imm <= '0;
            tail_tag <= '0;
            tail_ill <= 1'b0;
        end else if (load_tail) begin
            tail_imm <= new_imm;
            tail_tag <= in_tag;
            tail_ill <= new_illegal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_imm <= '0;
            head_tag <= '0;
            head_ill <= 1'b0;
        end else if (load_head_new) begin
            head_imm <= new_imm;
            head_tag <= in_tag;
            head_ill <= new_illegal;
        end else if (load_head_tail) begin
            head_imm <= tail_imm;
            head_tag <= tail_tag;
            head_ill <= tail_ill;
        end
    end

    assign out_imm     = head_imm;
    assign out_tag     = head_tag;
    assign out_illegal = head_ill;

`ifdef IMM_GEN_PC_ADD_EN
    logic [XLEN-1:0] head_target, tail_target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tail_target <= '0;
        end else if (load_tail) begin
            tail_target <= new_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_target <= '0;
        end else if (load_head_new) begin
            head_target <= new_target;
        end else if (load_head_tail) begin
            head_target <= tail_target;
        end
    end

    assign out_target = head_target;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe (XLEN 32 and 64 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_enc;
    logic [TAG_W-1:0] in_tag;
    logic             in_ready, out_valid, out_illegal;
    logic [31:0]      out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             in_ready64, out_valid64, out_illegal64;
    logic [63:0]      out_imm64;
    logic [TAG_W-1:0] out_tag64;
`ifdef IMM_GEN_PC_ADD_EN
    logic [31:0]      in_pc, out_target;
    logic [63:0]      in_pc64, out_target64;
    assign in_pc64 = {32'd0, in_pc};
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_enc(in_enc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal)
`ifdef IMM_GEN_PC_ADD_EN
        , .in_pc(in_pc), .out_target(out_target)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_enc(in_enc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
`ifdef IMM_GEN_PC_ADD_EN
        , .in_pc(in_pc64), .out_target(out_target64)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference immediate as a 64-bit signed value, built with arithmetic shifts.
    function automatic longint ref_imm(input logic [31:0] ins, input logic [2:0] enc,
                                       output logic ill);
        longint ls;
        ls  = longint'($signed(ins));
        ill = 1'b0;
        case (enc)
            3'd0: ref_imm = 0;
            3'd1: ref_imm = ls >>> 20;
            3'd2: ref_imm = ((ls >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd3: ref_imm = ((ls >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                          | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd4: ref_imm = (ls >>> 12) <<< 12;
            3'd5: ref_imm = ((ls >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                          | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd6: ref_imm = longint'(ins[19:15]);
            default: begin
                ref_imm = longint'(ins);
                ill     = 1'b1;
            end
        endcase
    endfunction

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
        logic [63:0]      tgt;
    } ent_t;

    ent_t q[$];
    ent_t m_e;
    logic m_push, m_pop;
    logic [TAG_W-1:0] dut_tags[$];

    // Queue model of the buffer, advanced on the same edges as the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            q.delete();
        end else begin
            m_pop  = (q.size() != 0) && out_ready;
            m_push = in_valid && (q.size() < 2);
            if (m_push) begin
                m_e.imm = ref_imm(in_instr, in_enc, m_e.ill);
                m_e.tag = in_tag;
`ifdef IMM_GEN_PC_ADD_EN
                m_e.tgt = {32'd0, in_pc} + m_e.imm;
`else
                m_e.tgt = 64'd0;
`endif
            end
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(m_e);
        end
    end

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            chk("in_ready",    in_ready,    q.size() != 2);
            chk("out_valid",   out_valid,   q.size() != 0);
            chk("in_ready64",  in_ready64,  q.size() != 2);
            chk("out_valid64", out_valid64, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_imm",       out_imm,       q[0].imm[31:0]);
                chk("out_tag",       out_tag,       q[0].tag);
                chk("out_illegal",   out_illegal,   q[0].ill);
                chk("out_imm64",     out_imm64,     q[0].imm);
                chk("out_tag64",     out_tag64,     q[0].tag);
                chk("out_illegal64", out_illegal64, q[0].ill);
`ifdef IMM_GEN_PC_ADD_EN
                chk("out_target",   out_target,   q[0].tgt[31:0]);
                chk("out_target64", out_target64, q[0].tgt);
`endif
            end
            if (out_valid && out_ready) dut_tags.push_back(out_tag);
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [31:0] ins, input logic [2:0] enc,
                        input logic [TAG_W-1:0] tag);
        int budget = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_enc   = enc;
        in_tag   = tag;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: tag %0d never accepted", tag);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] rdy_pat = 8'b1011_0010;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_enc = '0; in_tag = '0;
`ifdef IMM_GEN_PC_ADD_EN
        in_pc = '0;
`endif
        idle(2);
        chk("rst_out_valid",   out_valid,   0);
        chk("rst_out_imm",     out_imm,     0);
        chk("rst_out_tag",     out_tag,     0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_out_imm64",   out_imm64,   0);
        chk("rst_in_ready",    in_ready,    1);
        reset = 1'b0;
        idle(1);

        // Hand-computed decode vectors, one-cycle latency into an empty buffer
        send(32'hFFF00093, 3'd1, 5'd1);
        chk("I_valid", out_valid, 1);
        chk("I_imm",   out_imm,   32'hFFFFFFFF);
        chk("I_ill",   out_illegal, 0);
        send(32'hFE000EE3, 3'd3, 5'd2);
        chk("B_imm",   out_imm,   32'hFFFFFFFC);
        send(32'h001000EF, 3'd5, 5'd3);
        chk("J_imm",   out_imm,   32'h00000800);
        send(32'h000FD073, 3'd6, 5'd4);
        chk("Z_imm",   out_imm,   32'h0000001F);
        send(32'h800000B7, 3'd4, 5'd5);
        chk("U_imm32", out_imm,   32'h80000000);
        chk("U_imm64", out_imm64, 64'hFFFFFFFF80000000);
        send(32'h12345678, 3'd7, 5'd6);
        chk("E7_imm",   out_imm,     32'h12345678);
        chk("E7_imm64", out_imm64,   64'h0000000012345678);
        chk("E7_ill",   out_illegal, 1);
        send(32'hFE112C23, 3'd2, 5'd7);
        chk("S_imm",   out_imm,   32'hFFFFFFF8);
        send(32'hFFFFFFB3, 3'd0, 5'd8);
        chk("R_imm",   out_imm,   32'h00000000);
        idle(2);

        // Mixed stream under a fixed out_ready pattern
        fork
            for (int i = 0; i < 16; i++)
                send(32'hA5A50000 ^ (32'h13579BDF * i), 3'(i % 8), 5'(i + 10));
            for (int k = 0; k < 40; k++) begin
                out_ready = rdy_pat[k % 8];
                @(negedge clk);
            end
        join
        out_ready = 1'b1;
        idle(4);

        // Backpressure: tag 3 stalls behind a full buffer, then drains in order
        out_ready = 1'b0;
        send(32'h00500093, 3'd1, 5'd1);
        send(32'h00600093, 3'd1, 5'd2);
        in_valid = 1'b1; in_instr = 32'h00700093; in_enc = 3'd1; in_tag = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_head_tag", out_tag, 1);
            @(negedge clk);
        end
        dut_tags.delete();
        out_ready = 1'b1;
        for (int b = 0; b < 20 && !in_ready; b++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        idle(3);
        chk("bp_drain_n", dut_tags.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_drain_%0d", i),
                (i < dut_tags.size()) ? dut_tags[i] : 5'h1F, 5'(i + 1));

        // Flush with a full buffer and a pending input
        out_ready = 1'b0;
        send(32'h00100093, 3'd1, 5'd7);
        send(32'h00200093, 3'd1, 5'd8);
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd9;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready",  in_ready,  1);
        dut_tags.delete();
        out_ready = 1'b1;
        idle(3);
        chk("fl_nothing_out", dut_tags.size(), 0);

        // Flush beats a push that would otherwise be accepted
        out_ready = 1'b0;
        send(32'h00300093, 3'd1, 5'd10);
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd11;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_out_valid", out_valid, 0);
        out_ready = 1'b1;
        idle(2);

        // Asynchronous reset with a full buffer
        out_ready = 1'b0;
        send(32'hFFF00093, 3'd1, 5'd12);
        send(32'hFFF00093, 3'd1, 5'd13);
        #3 reset = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_imm",   out_imm,   0);
        chk("ar_out_tag",   out_tag,   0);
        chk("ar_out_imm64", out_imm64, 0);
        chk("ar_in_ready",  in_ready,  1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(2);

`ifdef IMM_GEN_PC_ADD_EN
        in_pc = 32'h00000100;
        send(32'hFE000EE3, 3'd3, 5'd14);
        chk("pc_B_target", out_target, 32'h000000FC);
        in_pc = 32'hFFFFFFFC;
        send(32'h0080006F, 3'd5, 5'd15);
        chk("pc_J_wrap",    out_target,   32'h00000004);
        chk("pc_J_wrap64",  out_target64, 64'h0000000100000004);
        idle(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
